div_unit: RTL and testbench

Multi-cycle 32-bit divider for DIV/DIVU, placed beside the execute stage. The execute stage issues operands with a start/ready handshake. The divider produces the 64-bit {remainder, quotient} pair that the execute stage forwards toward the HI/LO register. It uses a radix-2 restoring algorithm: one quotient bit per cycle, fixed latency, and abort on pipeline flush.

---
 rtl/div_unit_pkg.sv | 13 +
 rtl/div_unit.sv | 114 +++++++++++
 tb/tb_div_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths, state encodings and result constants for div_unit
package div_unit_pkg;
  typedef logic [31:0] reg_data_bus_t;
  typedef logic [63:0] double_reg_bus_t;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
endpackage

// File: rtl/div_unit.sv
// div_unit: 32-bit radix-2 restoring divider for DIV/DIVU; signed support enabled by DIV_SIGNED_EN
module div_unit
  import div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            annul_i,
  input  logic            signed_div_i,
  input  reg_data_bus_t   opdata1_i,
  input  reg_data_bus_t   opdata2_i,
  output double_reg_bus_t result_o,
  output logic            ready_o
);
  div_state_e      state, state_n;
  reg_data_bus_t   rem, rem_n, quo, quo_n, dsr, dsr_n;
  logic [4:0]      cnt, cnt_n;
  logic            ready_n;
  double_reg_bus_t result_n;
  logic [32:0]     trial;
  reg_data_bus_t   rem_s, quo_s, rem_fix, quo_fix, op1_mag, op2_mag;
  logic            accept;
  // One restoring step: the quotient MSB shifts into the partial remainder, keep the difference if it fits.
  assign trial  = {rem, quo[31]} - {1'b0, dsr};
  assign rem_s  = trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
  assign quo_s  = {quo[30:0], ~trial[32]};
  assign accept = (state == DivFree) && start_i && !annul_i && (opdata2_i != '0);
`ifdef DIV_SIGNED_EN
  logic neg_a, neg_b, sa, sb;
  assign neg_a   = signed_div_i & opdata1_i[31];
  assign neg_b   = signed_div_i & opdata2_i[31];
  assign op1_mag = neg_a ? -opdata1_i : opdata1_i;
  assign op2_mag = neg_b ? -opdata2_i : opdata2_i;
  assign quo_fix = (sa ^ sb) ? -quo_s : quo_s;
  assign rem_fix = sa ? -rem_s : rem_s;
  // capture operand signs at accept for the fix-up on the final iteration
  always_ff @(posedge clk or negedge rst)
    if (!rst) {sa, sb} <= 2'b00;
    else if (accept) {sa, sb} <= {neg_a, neg_b};
`else
  logic sign_unused;
  assign sign_unused = signed_div_i;
  assign op1_mag     = opdata1_i;
  assign op2_mag     = opdata2_i;
  assign quo_fix     = quo_s;
  assign rem_fix     = rem_s;
`endif
  // next-state and datapath updates; ready/result are registered from END so inputs never reach outputs combinationally
  always_comb begin
    state_n  = state;
    rem_n    = rem;
    quo_n    = quo;
    dsr_n    = dsr;
    cnt_n    = cnt;
    ready_n  = DivResultNotReady;
    result_n = '0;
    case (state)
      DivFree: begin
        if (start_i && !annul_i && opdata2_i == '0) state_n = DivByZero;
        else if (accept) begin
          state_n = DivOn;
          rem_n   = '0;
          quo_n   = op1_mag;
          dsr_n   = op2_mag;
          cnt_n   = '0;
        end
      end
      DivByZero: begin
        state_n = DivEnd;
        rem_n   = '0;
        quo_n   = '0;
      end
      DivOn: begin
        if (annul_i) state_n = DivFree;
        else if (cnt == 5'd31) begin
          state_n = DivEnd;
          rem_n   = rem_fix;
          quo_n   = quo_fix;
          cnt_n   = '0;
        end else begin
          rem_n = rem_s;
          quo_n = quo_s;
          cnt_n = cnt + 5'd1;
        end
      end
      default: begin
        if (annul_i || !start_i) state_n = DivFree;
        else begin
          ready_n  = DivResultReady;
          result_n = {rem, quo};
        end
      end
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= DivFree;
      rem      <= '0;
      quo      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      quo      <= quo_n;
      dsr      <= dsr_n;
      cnt      <= cnt_n;
      ready_o  <= ready_n;
      result_o <= result_n;
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit (signed expectations follow DIV_SIGNED_EN)
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, start_i, annul_i, signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  int          total = 0;
  int          bad = 0;
  logic [63:0] sb_q[$];
`ifdef DIV_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  div_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
    .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    logic [31:0] q, r;
    if (b == 32'h0) return 64'h0;
    if (s && SGN_EN) begin
      if (a == 32'h8000_0000 && b == 32'hffff_ffff) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s);
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    sb_q.push_back(model(a, b, s));
  endtask

  task automatic wait_ready(input string tag, input int lat);
    int k = 0;
    logic [63:0] exp;
    while (!ready_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 64'(k - 1), 64'(lat));
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hdead_beef_dead_beef;
    check(tag, result_o, exp);
    repeat (2) @(negedge clk);
    check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
    check({tag, "_hold_res"}, result_o, exp);
    start_i = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, {63'(result_o), ready_o}, 64'd0);
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(negedge clk);
    check("reset_rdy", 64'(ready_o), 64'd0);
    check("reset_res", result_o, 64'd0);
    rst = 1'b1;

    issue(32'd100, 32'd7, 1'b0);
    wait_ready("divu_100_7", 33);
    issue(-32'sd7, 32'd2, 1'b1);
    wait_ready("div_m7_2", 33);
    issue(32'd7, -32'sd2, 1'b1);
    wait_ready("div_7_m2", 33);
    issue(32'd12345, 32'd0, 1'b0);
    wait_ready("div_zero", 2);
    issue(32'h8000_0000, 32'hffff_ffff, 1'b1);
    wait_ready("div_ovf", 33);
    issue(32'hffff_ffff, 32'd1, 1'b0);
    wait_ready("divu_max_1", 33);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> (i * 5);
      issue(a, b, i[0]);
      wait_ready($sformatf("rand%0d", i), (b == 0) ? 2 : 33);
    end

    issue(32'd1000, 32'd3, 1'b0);
    void'(sb_q.pop_back());
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_rdy", 64'(ready_o), 64'd0);
    issue(32'd1000, 32'd3, 1'b0);
    wait_ready("after_annul", 33);

    @(negedge clk);
    opdata1_i = 32'd77; opdata2_i = 32'd5; signed_div_i = 1'b0;
    start_i = 1'b1; annul_i = 1'b1;
    sb_q.push_back(model(32'd77, 32'd5, 1'b0));
    @(negedge clk);
    annul_i = 1'b0;
    wait_ready("annul_wins", 33);

    issue(32'd50, 32'd5, 1'b0);
    void'(sb_q.pop_back());
    repeat (15) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_rdy", 64'(ready_o), 64'd0);
    check("rst_mid_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    issue(32'hffff_ffff, 32'd1, 1'b0);
    wait_ready("after_rst", 33);

    issue(32'd99, 32'd10, 1'b0);
    void'(sb_q.pop_back());
    repeat (40) @(negedge clk);
    check("end_pre_rdy", 64'(ready_o), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_end_rdy", 64'(ready_o), 64'd0);
    check("rst_end_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
